window_3x3_gen: RTL
===================

Name: window_3x3_gen

Overview:
- Upstream neighbour of the 9-input median sorter.
- Accepts a raster-order pixel stream (one pixel per clk when valid) and buffers two image lines internally.
- Emits a 3x3 neighbourhood in row-major order (w1..w9) with a valid strobe, ready to drive the sorter inputs i1..i9 directly.
- Only windows lying fully inside the image are flagged valid.

Parameters:
- n, 8, pixel width in bits
- IMG_W, 640, image width in pixels (>= 3)
- IMG_H, 480, image height in lines (>= 3)
- AW, 10, width of row/column counters and coordinate outputs; must hold max(IMG_W, IMG_H) - 1

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- pix_in  input  n  incoming pixel
- pix_valid  input  1  pix_in is accepted this cycle
- sof  input  1  start of frame; qualified by pix_valid; marks pix_in as pixel (0,0)
- w1..w9  output  n each  window, row-major: w1..w3 top row (oldest column first), w4..w6 middle row, w7..w9 bottom row
- win_valid  output  1  w1..w9 hold a complete in-image window
- ctr_row  output  AW  row of the window centre (w5)
- ctr_col  output  AW  column of the window centre (w5)
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (reset=0, async):
  - w1..w9, ctr_row, ctr_col, row/col counters = 0; win_valid, frame_done = 0.
  - Line buffer RAMs are not cleared; stale contents are never flagged valid.
- State: counters (row, col) give the position of the next accepted pixel. Storage is two line buffers, lb1 (line r-1) and lb2 (line r-2), each IMG_W deep and indexed by col. The window is a 3x3 register array.
- Accepted pixel (pix_valid=1) at position (r,c), single cycle:
  - Window shifts one column left; the new right column is top=lb2[c], mid=lb1[c], bot=pix_in.
  - lb2[c] <= old lb1[c]; lb1[c] <= pix_in (read-before-write on the same index).
  - win_valid <= (r >= 2 && c >= 2); ctr_row <= r-1, ctr_col <= c-1 when valid, otherwise held.
  - Counters advance: c == IMG_W-1 wraps c to 0 and increments r. Pixel (IMG_H-1, IMG_W-1) returns counters to (0,0) and sets frame_done <= 1 for one cycle.
- Latency: window and win_valid appear 1 clk after the pixel that completes the window.
- pix_valid=0: counters, line buffers and window hold; win_valid <= 0, frame_done <= 0. Gaps of any length are legal, including mid-line.
- sof with pix_valid: pixel is taken as (0,0) regardless of counter state and counters continue from (0,1). An sof arriving mid-frame aborts the old frame with no frame_done.
- sof without pix_valid: ignored.
- Row boundary: at c=0 and c=1 the window still contains the previous line's right-edge columns; win_valid=0, so the contents are don't-care.
- Windows per frame: exactly (IMG_W-2)*(IMG_H-2) win_valid pulses. No border padding.
- Reset mid-frame: all state returns to reset values; the next accepted pixel is (0,0) even without sof.
- Line buffers map to inferred single-port-per-cycle RAM (one read plus one write at the same address); combinational output path is none, all outputs are registered.

Test Plan:
- IMG_W=4, IMG_H=4, continuous stream, pixel value = 16*r+c, sof on the first pixel -> first win_valid 1 clk after pixel (2,2). Required window: w1..w9 = 0,1,2,16,17,18,32,33,34; ctr=(1,1).
- Same frame, continued -> exactly 4 win_valid pulses with centres (1,1),(1,2),(2,1),(2,2). Last window is 17,18,19,33,34,35,49,50,51. frame_done pulses 1 clk after pixel (3,3).
- Same frame with pix_valid deasserted for 3 cycles between (2,2) and (2,3) -> identical windows and ordering. win_valid is low during the gap; the second window appears 1 clk after (2,3).
- Reset asserted after pixel (2,1), then the frame is restarted -> all outputs 0 during reset. Re-sent frame yields the same 4 windows with no window from the aborted data.
- sof asserted at pixel index 6 of an unfinished frame, followed by a full 4x4 frame -> no frame_done for the aborted frame. Exactly 4 valid windows with values as in the first two scenarios.
- Two back-to-back frames (second with all values +100), no gap -> 8 windows total. The first window of frame 2 is 100,101,102,116,117,118,132,133,134; two frame_done pulses.

Source files
------------

// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window generator for a raster pixel stream, buffering two lines.
// Emits row-major windows (w1..w9) for in-image positions only, all outputs registered.
module window_3x3_gen #(
  parameter int n     = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [n-1:0]  pix_in,
  input  logic          pix_valid,
  input  logic          sof,
  output logic [n-1:0]  w1,
  output logic [n-1:0]  w2,
  output logic [n-1:0]  w3,
  output logic [n-1:0]  w4,
  output logic [n-1:0]  w5,
  output logic [n-1:0]  w6,
  output logic [n-1:0]  w7,
  output logic [n-1:0]  w8,
  output logic [n-1:0]  w9,
  output logic          win_valid,
  output logic [AW-1:0] ctr_row,
  output logic [AW-1:0] ctr_col,
  output logic          frame_done
);

  localparam int LW = $clog2(IMG_W);

  logic [n-1:0]  lb1 [IMG_W];
  logic [n-1:0]  lb2 [IMG_W];
  logic [AW-1:0] row, col;
  logic [AW-1:0] r_cur, c_cur;
  logic [LW-1:0] idx;
  logic [n-1:0]  top, mid;

  // sof overrides the counters so the flagged pixel lands at (0,0)
  always_comb begin
    r_cur = sof ? '0 : row;
    c_cur = sof ? '0 : col;
    idx   = c_cur[LW-1:0];
    top   = lb2[idx];
    mid   = lb1[idx];
  end

  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb2[idx] <= mid;
      lb1[idx] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row        <= '0;
      col        <= '0;
      w1         <= '0;
      w2         <= '0;
      w3         <= '0;
      w4         <= '0;
      w5         <= '0;
      w6         <= '0;
      w7         <= '0;
      w8         <= '0;
      w9         <= '0;
      win_valid  <= 1'b0;
      ctr_row    <= '0;
      ctr_col    <= '0;
      frame_done <= 1'b0;
    end else if (pix_valid) begin
      w1 <= w2;
      w2 <= w3;
      w3 <= top;
      w4 <= w5;
      w5 <= w6;
      w6 <= mid;
      w7 <= w8;
      w8 <= w9;
      w9 <= pix_in;
      win_valid  <= (r_cur >= AW'(2)) && (c_cur >= AW'(2));
      frame_done <= 1'b0;
      if ((r_cur >= AW'(2)) && (c_cur >= AW'(2))) begin
        ctr_row <= r_cur - AW'(1);
        ctr_col <= c_cur - AW'(1);
      end
      if (c_cur == AW'(IMG_W - 1)) begin
        col <= '0;
        if (r_cur == AW'(IMG_H - 1)) begin
          row        <= '0;
          frame_done <= 1'b1;
        end else begin
          row <= r_cur + AW'(1);
        end
      end else begin
        row <= r_cur;
        col <= c_cur + AW'(1);
      end
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule
